// File: rtl/aui_sched_pkg.sv
// Shared defaults and types for the RS group scheduler and its AM gap timer.
package aui_sched_pkg;

    localparam int DEF_WORD_WIDTH = 5440;
    localparam int DEF_AM_PERIOD  = 8192;
    localparam int DEF_AM_CYCLES  = 1;

    typedef enum logic {ST_AM, ST_RUN} sched_state_e;

    typedef logic [1:0] slot_idx_t;

endpackage

// File: rtl/am_gap_timer.sv
// Output-side sequencer: AM gap countdown, per-period group index and the
// RUN/AM state that gates transfers into the output register.
module am_gap_timer
    import aui_sched_pkg::*;
#(
    parameter int AM_PERIOD = DEF_AM_PERIOD,
    parameter int AM_CYCLES = DEF_AM_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hs,
    output logic                         am_slot,
    output logic                         run,
    output logic                         wrap,
    output logic [$clog2(AM_PERIOD)-1:0] group_idx
);

    localparam int IDX_W = $clog2(AM_PERIOD);
    localparam int GAP_W = (AM_CYCLES > 1) ? $clog2(AM_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(AM_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(AM_PERIOD - 1);

    sched_state_e      state_reg, state_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [IDX_W-1:0]  idx_reg;

    // Handshake of the last group in the period starts the next gap.
    assign wrap = hs && (idx_reg == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_AM;
            gap_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            if (hs) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        case (state_reg)
            ST_AM: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_RUN;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    state_next = ST_AM;
                end
            end
            default: state_next = ST_AM;
        endcase
    end

    assign am_slot   = (state_reg == ST_AM) && !rst;
    assign run       = (state_reg == ST_RUN);
    assign group_idx = idx_reg;

endmodule

// File: rtl/rs_group_scheduler.sv
// Collects serial RS codewords into A/B/C/D groups and hands them to the
// 16-lane distributor, leaving an AM gap before each AM period.
module rs_group_scheduler
    import aui_sched_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int AM_PERIOD  = DEF_AM_PERIOD,
    parameter int AM_CYCLES  = DEF_AM_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WORD_WIDTH-1:0]        s_data,
    input  logic                         s_first,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WORD_WIDTH-1:0]        m_word_a,
    output logic [WORD_WIDTH-1:0]        m_word_b,
    output logic [WORD_WIDTH-1:0]        m_word_c,
    output logic [WORD_WIDTH-1:0]        m_word_d,
    output logic                         m_sync,
    output logic                         am_slot,
    output logic [$clog2(AM_PERIOD)-1:0] group_idx,
    output logic                         err_align
);

    slot_idx_t             idx_reg, idx_next;
    logic                  cfull_reg, cfull_next;
    logic                  err_reg;
    logic                  m_valid_reg, m_sync_reg;
    logic [WORD_WIDTH-1:0] slot_reg [4];
    logic [WORD_WIDTH-1:0] out_reg  [4];
    logic [3:0]            slot_we;
    logic                  accept, hs, xfer, run, wrap, resync;

    am_gap_timer #(
        .AM_PERIOD (AM_PERIOD),
        .AM_CYCLES (AM_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .hs        (hs),
        .am_slot   (am_slot),
        .run       (run),
        .wrap      (wrap),
        .group_idx (group_idx)
    );

    assign hs      = m_valid_reg && m_ready;
    // A wrapping handshake must drain the output before the gap opens.
    assign xfer    = cfull_reg && run && (!m_valid_reg || m_ready) && !wrap;
    assign s_ready = !rst && (!cfull_reg || xfer);
    assign accept  = s_valid && s_ready;
    assign resync  = s_first || (idx_reg == 2'd0);

    always_comb begin
        idx_next   = idx_reg;
        cfull_next = cfull_reg && !xfer;
        slot_we    = '0;
        if (accept) begin
            if (resync) begin
                slot_we[0] = 1'b1;
                idx_next   = 2'd1;
            end else begin
                slot_we[idx_reg] = 1'b1;
                idx_next         = idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    cfull_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg     <= '0;
            cfull_reg   <= 1'b0;
            err_reg     <= 1'b0;
            m_valid_reg <= 1'b0;
            m_sync_reg  <= 1'b0;
        end else begin
            idx_reg   <= idx_next;
            cfull_reg <= cfull_next;
            if (accept && (s_first != (idx_reg == 2'd0))) begin
                err_reg <= 1'b1;
            end
            if (xfer) begin
                m_valid_reg <= 1'b1;
                // A reload during a handshake is never group 0: wraps block xfer.
                m_sync_reg  <= !m_valid_reg && (group_idx == '0);
            end else if (hs) begin
                m_valid_reg <= 1'b0;
                m_sync_reg  <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                slot_reg[gi] <= '0;
                out_reg[gi]  <= '0;
            end else begin
                if (slot_we[gi]) begin
                    slot_reg[gi] <= s_data;
                end
                if (xfer) begin
                    out_reg[gi] <= slot_reg[gi];
                end
            end
        end
    end

    assign m_valid   = m_valid_reg;
    assign m_sync    = m_sync_reg;
    assign err_align = err_reg;
    assign m_word_a  = out_reg[0];
    assign m_word_b  = out_reg[1];
    assign m_word_c  = out_reg[2];
    assign m_word_d  = out_reg[3];

endmodule

// File: tb/tb_rs_group_scheduler.sv
// Randomized bench for rs_group_scheduler against a word-stream/group-queue model.
module tb_rs_group_scheduler;

    localparam int W = 16;
    localparam int P = 4;
    localparam int C = 2;

    logic           clk = 1'b0;
    logic           rst, s_valid, s_ready, s_first;
    logic           m_valid, m_ready, m_sync, am_slot, err_align;
    logic [W-1:0]   s_data, m_word_a, m_word_b, m_word_c, m_word_d;
    logic [1:0]     group_idx;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    int             grp_cnt = 0;
    logic [W-1:0]   part[$];
    logic [4*W-1:0] exp_q[$];
    int             done_q[$];
    logic           exp_err = 1'b0;
    logic           err_chk = 1'b0;

    rs_group_scheduler #(
        .WORD_WIDTH (W),
        .AM_PERIOD  (P),
        .AM_CYCLES  (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_first   (s_first),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_word_a  (m_word_a),
        .m_word_b  (m_word_b),
        .m_word_c  (m_word_c),
        .m_word_d  (m_word_d),
        .m_sync    (m_sync),
        .am_slot   (am_slot),
        .group_idx (group_idx),
        .err_align (err_align)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, sample 1 time unit later, and feed
    // accepted words to the model: a group is any four words that begin with a
    // start word; a start flag mid-group or a group begun without one is an error.
    task automatic tick(input logic v, input logic f, input logic [W-1:0] d,
                        input logic mr, output logic acc, output logic hs);
        @(negedge clk);
        rst = 1'b0; s_valid = v; s_first = f; s_data = d; m_ready = mr;
        #1;
        cyc++;
        acc     = s_valid && s_ready;
        hs      = m_valid && m_ready;
        err_chk = exp_err;
        if (acc) begin
            if (f || part.size() == 0) begin
                if (f != (part.size() == 0)) exp_err = 1'b1;
                part.delete();
                part.push_back(d);
            end else begin
                part.push_back(d);
                if (part.size() == 4) begin
                    exp_q.push_back({part[0], part[1], part[2], part[3]});
                    done_q.push_back(cyc);
                    part.delete();
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0; m_ready = 1'b0;
        part.delete(); exp_q.delete(); done_q.delete();
        grp_cnt = 0; exp_err = 1'b0;
    endtask

    task automatic test_reset();
        logic acc, hs, e_sync;
        logic [1:0] e_idx;
        logic [4*W-1:0] exp_w;
        int t, wi;
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0; m_ready = 1'b1;
        part.delete(); exp_q.delete(); done_q.delete(); grp_cnt = 0; exp_err = 1'b0;
        #1;
        n_tests++;
        if ({am_slot, s_ready} !== 2'b00) begin
            n_fail++; $display("FAIL rst_cycle: am_slot,s_ready=%b expected 00", {am_slot, s_ready});
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({m_valid, m_sync, err_align, group_idx, m_word_a, m_word_b, m_word_c, m_word_d} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b sync=%b err=%b idx=%0d words=%h expected all 0",
                     m_valid, m_sync, err_align, group_idx, {m_word_a, m_word_b, m_word_c, m_word_d});
        end
        wi = 0;
        for (int k = 0; k < 60 && (wi < 12 || exp_q.size() != 0); k++) begin
            tick(wi < 12, part.size() == 0, W'($urandom), 1'b1, acc, hs);
            if (acc) wi++;
            if (k < 3) begin
                n_tests++;
                if (am_slot !== (k < C)) begin
                    n_fail++; $display("FAIL am_after_reset: cycle %0d am_slot=%b expected %b", k + 1, am_slot, k < C);
                end
            end
            n_tests++;
            if (am_slot && m_valid) begin
                n_fail++; $display("FAIL am_mutex: am_slot and m_valid both high at cycle %0d", cyc);
            end
            if (hs) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL group_extra: got %h expected none", {m_word_a, m_word_b, m_word_c, m_word_d});
                end else begin
                    exp_w = exp_q.pop_front(); t = done_q.pop_front();
                    e_idx = 2'(grp_cnt % P); e_sync = (grp_cnt % P) == 0;
                    if ({m_word_a, m_word_b, m_word_c, m_word_d} !== exp_w) begin
                        n_fail++; $display("FAIL group_data: got %h expected %h", {m_word_a, m_word_b, m_word_c, m_word_d}, exp_w);
                    end
                    n_tests++;
                    if ({m_sync, group_idx} !== {e_sync, e_idx}) begin
                        n_fail++; $display("FAIL group_tag: sync=%b idx=%0d expected sync=%b idx=%0d", m_sync, group_idx, e_sync, e_idx);
                    end
                end
                $display("[TB] reset   group %0d idx=%0d sync=%b data=%h", grp_cnt, group_idx, m_sync, {m_word_a, m_word_b, m_word_c, m_word_d});
                grp_cnt++;
            end
        end
        n_tests++;
        if (grp_cnt != 3 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_stream_count: groups=%0d pending=%0d expected 3 and 0", grp_cnt, exp_q.size());
        end
    endtask

    task automatic test_stream();
        logic acc, hs, e_sync;
        logic [1:0] e_idx;
        logic [4*W-1:0] exp_w;
        int t, wi, am_len, gaps;
        do_reset();
        wi = 0; am_len = 0; gaps = 0;
        for (int k = 0; k < 80 && (wi < 20 || exp_q.size() != 0 || am_len != 0); k++) begin
            tick(wi < 20, part.size() == 0, W'($urandom), 1'b1, acc, hs);
            if (acc) wi++;
            if (am_slot) am_len++;
            else if (am_len != 0) begin
                n_tests++;
                if (am_len != C) begin
                    n_fail++; $display("FAIL gap_len: got %0d cycles expected %0d", am_len, C);
                end
                am_len = 0; gaps++;
            end
            n_tests++;
            if (am_slot && m_valid) begin
                n_fail++; $display("FAIL am_mutex: am_slot and m_valid both high at cycle %0d", cyc);
            end
            if (hs) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL group_extra: got %h expected none", {m_word_a, m_word_b, m_word_c, m_word_d});
                end else begin
                    exp_w = exp_q.pop_front(); t = done_q.pop_front();
                    e_idx = 2'(grp_cnt % P); e_sync = (grp_cnt % P) == 0;
                    if ({m_word_a, m_word_b, m_word_c, m_word_d} !== exp_w) begin
                        n_fail++; $display("FAIL group_data: got %h expected %h", {m_word_a, m_word_b, m_word_c, m_word_d}, exp_w);
                    end
                    n_tests++;
                    if ({m_sync, group_idx} !== {e_sync, e_idx}) begin
                        n_fail++; $display("FAIL group_tag: sync=%b idx=%0d expected sync=%b idx=%0d", m_sync, group_idx, e_sync, e_idx);
                    end
                    n_tests++;
                    if (cyc - t != 2) begin
                        n_fail++; $display("FAIL latency: group %0d took %0d cycles expected 2", grp_cnt, cyc - t);
                    end
                end
                $display("[TB] stream  group %0d idx=%0d sync=%b data=%h", grp_cnt, group_idx, m_sync, {m_word_a, m_word_b, m_word_c, m_word_d});
                grp_cnt++;
            end
        end
        n_tests++;
        if (wi != 20 || grp_cnt != 5 || gaps != 2 || exp_q.size() != 0 || part.size() != 0) begin
            n_fail++;
            $display("FAIL stream_totals: words=%0d groups=%0d gaps=%0d pending=%0d expected 20,5,2,0",
                     wi, grp_cnt, gaps, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic acc, hs, e_sync;
        logic [1:0] e_idx;
        logic [4*W-1:0] exp_w, held;
        int t, wi, n_acc, n_hs;
        wi = 0;
        for (int k = 0; k < 30 && (wi < 4 || !m_valid); k++) begin
            tick(wi < 4, part.size() == 0, W'($urandom), 1'b0, acc, hs);
            if (acc) wi++;
        end
        n_tests++;
        if (m_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_load: m_valid=%b expected 1", m_valid);
        end
        held = {m_word_a, m_word_b, m_word_c, m_word_d};
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, part.size() == 0, W'($urandom), 1'b0, acc, hs);
            if (acc) n_acc++;
            n_tests++;
            if ({m_valid, m_word_a, m_word_b, m_word_c, m_word_d} !== {1'b1, held}) begin
                n_fail++; $display("FAIL bp_stable: valid=%b words=%h expected 1 %h", m_valid, {m_word_a, m_word_b, m_word_c, m_word_d}, held);
            end
        end
        n_tests++;
        if (n_acc != 4 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_fill: accepted=%0d s_ready=%b expected 4 and 0", n_acc, s_ready);
        end
        n_hs = 0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1, acc, hs);
            n_tests++;
            if (am_slot && m_valid) begin
                n_fail++; $display("FAIL am_mutex: am_slot and m_valid both high at cycle %0d", cyc);
            end
            if (hs) begin
                n_hs++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL group_extra: got %h expected none", {m_word_a, m_word_b, m_word_c, m_word_d});
                end else begin
                    exp_w = exp_q.pop_front(); t = done_q.pop_front();
                    e_idx = 2'(grp_cnt % P); e_sync = (grp_cnt % P) == 0;
                    if ({m_word_a, m_word_b, m_word_c, m_word_d} !== exp_w) begin
                        n_fail++; $display("FAIL group_data: got %h expected %h", {m_word_a, m_word_b, m_word_c, m_word_d}, exp_w);
                    end
                    n_tests++;
                    if ({m_sync, group_idx} !== {e_sync, e_idx}) begin
                        n_fail++; $display("FAIL group_tag: sync=%b idx=%0d expected sync=%b idx=%0d", m_sync, group_idx, e_sync, e_idx);
                    end
                end
                $display("[TB] bpress  group %0d idx=%0d sync=%b data=%h", grp_cnt, group_idx, m_sync, {m_word_a, m_word_b, m_word_c, m_word_d});
                grp_cnt++;
            end
        end
        n_tests++;
        if (n_hs != 2 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_release: groups=%0d pending=%0d expected 2 and 0", n_hs, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic acc, hs, e_sync, f;
        logic [1:0] e_idx;
        logic [4*W-1:0] exp_w;
        int t, wi;
        do_reset();
        wi = 0;
        for (int k = 0; k < 800 && (wi < 60 || exp_q.size() != 0); k++) begin
            f = (part.size() == 0);
            if ($urandom_range(9) == 0) f = 1'($urandom_range(1));
            tick((wi < 60) && ($urandom_range(3) != 0), f, W'($urandom), $urandom_range(2) != 0, acc, hs);
            if (acc) wi++;
            n_tests++;
            if ((am_slot && m_valid) || err_align !== err_chk) begin
                n_fail++; $display("FAIL rand_flags: am_slot=%b m_valid=%b err=%b expected err=%b", am_slot, m_valid, err_align, err_chk);
            end
            if (hs) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL group_extra: got %h expected none", {m_word_a, m_word_b, m_word_c, m_word_d});
                end else begin
                    exp_w = exp_q.pop_front(); t = done_q.pop_front();
                    e_idx = 2'(grp_cnt % P); e_sync = (grp_cnt % P) == 0;
                    if ({m_word_a, m_word_b, m_word_c, m_word_d} !== exp_w) begin
                        n_fail++; $display("FAIL group_data: got %h expected %h", {m_word_a, m_word_b, m_word_c, m_word_d}, exp_w);
                    end
                    n_tests++;
                    if ({m_sync, group_idx} !== {e_sync, e_idx}) begin
                        n_fail++; $display("FAIL group_tag: sync=%b idx=%0d expected sync=%b idx=%0d", m_sync, group_idx, e_sync, e_idx);
                    end
                end
                $display("[TB] random  group %0d idx=%0d sync=%b data=%h", grp_cnt, group_idx, m_sync, {m_word_a, m_word_b, m_word_c, m_word_d});
                grp_cnt++;
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: %0d groups pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_align();
        logic acc, hs, e_sync;
        logic [1:0] e_idx;
        logic [4*W-1:0] exp_w;
        logic [15:0] pat;
        int t, wi, nw;
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            // bit i is s_first of word i
            pat = (ph == 0) ? 16'b0000_0000_0100_0101 : 16'b0000_0000_0001_0000;
            nw  = (ph == 0) ? 10 : 8;
            wi  = 0;
            for (int k = 0; k < 200 && (wi < nw || exp_q.size() != 0); k++) begin
                tick(wi < nw, pat[wi % 16], W'($urandom), $urandom_range(1) != 0, acc, hs);
                if (acc) wi++;
                n_tests++;
                if (err_align !== err_chk) begin
                    n_fail++; $display("FAIL err_track: err_align=%b expected %b at cycle %0d", err_align, err_chk, cyc);
                end
                if (hs) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL group_extra: got %h expected none", {m_word_a, m_word_b, m_word_c, m_word_d});
                    end else begin
                        exp_w = exp_q.pop_front(); t = done_q.pop_front();
                        e_idx = 2'(grp_cnt % P); e_sync = (grp_cnt % P) == 0;
                        if ({m_word_a, m_word_b, m_word_c, m_word_d} !== exp_w) begin
                            n_fail++; $display("FAIL group_data: got %h expected %h", {m_word_a, m_word_b, m_word_c, m_word_d}, exp_w);
                        end
                        n_tests++;
                        if ({m_sync, group_idx} !== {e_sync, e_idx}) begin
                            n_fail++; $display("FAIL group_tag: sync=%b idx=%0d expected sync=%b idx=%0d", m_sync, group_idx, e_sync, e_idx);
                        end
                    end
                    $display("[TB] align%0d  group %0d idx=%0d sync=%b data=%h", ph, grp_cnt, group_idx, m_sync, {m_word_a, m_word_b, m_word_c, m_word_d});
                    grp_cnt++;
                end
            end
            tick(1'b0, 1'b0, '0, 1'b1, acc, hs);
            n_tests++;
            if (err_align !== 1'b1 || grp_cnt != 2) begin
                n_fail++; $display("FAIL align_err: phase %0d err_align=%b groups=%0d expected 1 and 2", ph, err_align, grp_cnt);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic acc, hs, e_sync;
        logic [1:0] e_idx;
        logic [4*W-1:0] exp_w;
        int t, wi;
        wi = 0;
        for (int k = 0; k < 40 && (wi < 6 || !m_valid); k++) begin
            tick(wi < 6, part.size() == 0, W'($urandom), 1'b0, acc, hs);
            if (acc) wi++;
        end
        n_tests++;
        if (m_valid !== 1'b1 || wi != 6) begin
            n_fail++; $display("FAIL mid_setup: m_valid=%b words=%0d expected 1 and 6", m_valid, wi);
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1, acc, hs);
            n_tests++;
            if ({m_valid, am_slot} !== {1'b0, k < C}) begin
                n_fail++; $display("FAIL mid_reset_gap: cycle %0d m_valid=%b am_slot=%b expected 0 %b", k + 1, m_valid, am_slot, k < C);
            end
        end
        wi = 0;
        for (int k = 0; k < 40 && (wi < 4 || exp_q.size() != 0); k++) begin
            tick(wi < 4, part.size() == 0, W'($urandom), 1'b1, acc, hs);
            if (acc) wi++;
            if (hs) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL group_extra: got %h expected none", {m_word_a, m_word_b, m_word_c, m_word_d});
                end else begin
                    exp_w = exp_q.pop_front(); t = done_q.pop_front();
                    e_idx = 2'(grp_cnt % P); e_sync = (grp_cnt % P) == 0;
                    if ({m_word_a, m_word_b, m_word_c, m_word_d} !== exp_w) begin
                        n_fail++; $display("FAIL group_data: got %h expected %h", {m_word_a, m_word_b, m_word_c, m_word_d}, exp_w);
                    end
                    n_tests++;
                    if ({m_sync, group_idx} !== {e_sync, e_idx}) begin
                        n_fail++; $display("FAIL group_tag: sync=%b idx=%0d expected sync=%b idx=%0d", m_sync, group_idx, e_sync, e_idx);
                    end
                end
                $display("[TB] midrst  group %0d idx=%0d sync=%b data=%h", grp_cnt, group_idx, m_sync, {m_word_a, m_word_b, m_word_c, m_word_d});
                grp_cnt++;
            end
        end
        n_tests++;
        if (grp_cnt != 1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL mid_reset_group: groups=%0d pending=%0d expected 1 and 0", grp_cnt, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0; m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_align();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
